// File: rtl/tx_lane_gearbox_pkg.sv
// Shared constants and types for the per-lane 64b/66b TX path.
package tx_lane_gearbox_pkg;

    localparam int ENCODED_DATA_SIZE = 66;
    localparam int TX_WIDTH          = 64;

    localparam logic [1:0]  SYNC_DATA    = 2'b01;
    localparam logic [1:0]  SYNC_CTRL    = 2'b10;
    localparam logic [63:0] IDLE_PAYLOAD = 64'h1E00_0000_0000_0000;

    localparam int SCR_LEN = 58;
    localparam int SCR_TAP = 39;

    localparam logic [5:0] GB_PAUSE_SEQ = 6'd32;

    typedef struct packed {
        logic [1:0]  header;
        logic [63:0] payload;
    } enc_block_t;

    // Mask of the n least-significant bits; n = 0 gives an empty mask.
    function automatic logic [63:0] low_mask(input logic [6:0] n);
        return (64'd1 << n) - 64'd1;
    endfunction

endpackage

// File: rtl/tx_scrambler_58.sv
// Combinational x^58+x^39+1 self-synchronous scrambler over one 64-bit payload.
module tx_scrambler_58
    import tx_lane_gearbox_pkg::*;
(
    input  logic [SCR_LEN-1:0] state_in,
    input  logic [63:0]        payload_in,
    output logic [63:0]        payload_out,
    output logic [SCR_LEN-1:0] state_out
);

    // hist[k] is scrambled bit S[k-58]: state_in fills the oldest 58 slots,
    // so each new bit reads its taps from already-computed positions.
    always_comb begin
        logic [SCR_LEN+63:0] hist;
        hist = '0;
        hist[SCR_LEN-1:0] = state_in;
        for (int unsigned i = 0; i < 64; i++) begin
            hist[i+SCR_LEN] = payload_in[i] ^ hist[i+SCR_LEN-SCR_TAP] ^ hist[i];
        end
        payload_out = hist[SCR_LEN+63:SCR_LEN];
        state_out   = hist[SCR_LEN+63:64];
    end

endmodule

// File: rtl/tx_lane_gearbox.sv
// Per-lane TX stage: scrambles 66-bit blocks and packs them into 64-bit words (32 blocks -> 33 words).
module tx_lane_gearbox
    import tx_lane_gearbox_pkg::*;
#(
    parameter int          TX_WIDTH     = tx_lane_gearbox_pkg::TX_WIDTH,
    parameter bit          SCRAMBLE_EN  = 1'b1,
    parameter logic [63:0] IDLE_PAYLOAD = tx_lane_gearbox_pkg::IDLE_PAYLOAD
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         blk_valid,
    input  logic [ENCODED_DATA_SIZE-1:0] blk_data,
    output logic                         blk_ready,
    output logic [TX_WIDTH-1:0]          tx_data,
    output logic                         tx_valid,
    output logic [5:0]                   tx_seq,
    output logic                         underrun
);

    logic [6:0]         fill;
    logic [63:0]        leftover;
    logic [SCR_LEN-1:0] scr_state;

    enc_block_t         src_blk;
    logic [63:0]        scr_payload;
    logic [SCR_LEN-1:0] scr_next;
    logic [65:0]        stream66;
    logic [127:0]       gear_word;
    logic               accept;

    assign accept    = enable && (tx_seq != GB_PAUSE_SEQ);
    assign blk_ready = accept;

    always_comb begin
        src_blk = blk_data;
        if (!blk_valid) begin
            src_blk.header  = SYNC_CTRL;
            src_blk.payload = IDLE_PAYLOAD;
        end
    end

    tx_scrambler_58 u_scrambler (
        .state_in    (scr_state),
        .payload_in  (src_blk.payload),
        .payload_out (scr_payload),
        .state_out   (scr_next)
    );

    // New block sits above the f valid leftover bits; anything beyond bit 63
    // becomes the next leftover.
    always_comb begin
        stream66  = {(SCRAMBLE_EN ? scr_payload : src_blk.payload), src_blk.header};
        gear_word = (128'(stream66) << fill) | 128'(leftover & low_mask(fill));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            tx_seq    <= '0;
            underrun  <= 1'b0;
            fill      <= '0;
            leftover  <= '0;
            scr_state <= '1;
        end else begin
            tx_valid <= enable;
            underrun <= 1'b0;
            if (accept) begin
                tx_data  <= gear_word[63:0];
                leftover <= gear_word[127:64];
                fill     <= fill + 7'd2;
                tx_seq   <= tx_seq + 6'd1;
                underrun <= !blk_valid;
                if (SCRAMBLE_EN) begin
                    scr_state <= scr_next;
                end
            end else if (enable) begin
                tx_data <= leftover;
                fill    <= '0;
                tx_seq  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_tx_lane_gearbox.sv
// Randomized bench for tx_lane_gearbox against a bit-stream reference model.
module tb_tx_lane_gearbox;

    localparam logic [63:0] IDLE = 64'h1E00_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst, enable, blk_valid;
    logic [65:0] blk_data;

    logic        s_ready, s_valid, s_under, n_ready, n_valid, n_under;
    logic [63:0] s_data, n_data;
    logic [5:0]  s_seq, n_seq;

    always #5 clk = ~clk;

    tx_lane_gearbox #(.SCRAMBLE_EN(1'b1)) dut_s (
        .clk(clk), .rst(rst), .enable(enable), .blk_valid(blk_valid), .blk_data(blk_data),
        .blk_ready(s_ready), .tx_data(s_data), .tx_valid(s_valid), .tx_seq(s_seq), .underrun(s_under)
    );

    tx_lane_gearbox #(.SCRAMBLE_EN(1'b0)) dut_n (
        .clk(clk), .rst(rst), .enable(enable), .blk_valid(blk_valid), .blk_data(blk_data),
        .blk_ready(n_ready), .tx_data(n_data), .tx_valid(n_valid), .tx_seq(n_seq), .underrun(n_under)
    );

    int          n_assert = 0;
    int          n_fail   = 0;

    // Reference model: serial scrambler history and the transmitted bit streams.
    int          seq_m;
    bit          hist[$];
    bit          sq1[$];
    bit          sq0[$];
    logic [63:0] ew1, ew0;
    logic        ev, eu, er;
    logic        ar1, ar0;

    task automatic model_reset();
        seq_m = 0;
        hist.delete();
        repeat (58) hist.push_back(1'b1);
        sq1.delete();
        sq0.delete();
        ew1 = '0; ew0 = '0; ev = 1'b0; eu = 1'b0;
    endtask

    task automatic scr_ref(input logic [63:0] d, output logic [63:0] s);
        bit b;
        for (int i = 0; i < 64; i++) begin
            b = d[i] ^ hist[19] ^ hist[0];
            s[i] = b;
            hist.push_back(b);
            void'(hist.pop_front());
        end
    endtask

    task automatic model_edge(input bit en, input bit v, input logic [65:0] d);
        logic [63:0] pl, sp;
        logic [1:0]  h;
        if (!en) begin
            ev = 1'b0; eu = 1'b0;
            return;
        end
        ev = 1'b1;
        if (seq_m == 32) begin
            seq_m = 0; eu = 1'b0;
        end else begin
            h  = v ? d[65:64] : 2'b10;
            pl = v ? d[63:0]  : IDLE;
            eu = !v;
            scr_ref(pl, sp);
            for (int i = 0; i < 2; i++) begin
                sq1.push_back(h[i]); sq0.push_back(h[i]);
            end
            for (int i = 0; i < 64; i++) begin
                sq1.push_back(sp[i]); sq0.push_back(pl[i]);
            end
            seq_m++;
        end
        for (int i = 0; i < 64; i++) begin
            ew1[i] = sq1.pop_front();
            ew0[i] = sq0.pop_front();
        end
    endtask

    task automatic step(input bit en, input bit v, input logic [65:0] d);
        @(negedge clk);
        enable = en; blk_valid = v; blk_data = d;
        #1;
        er  = en && (seq_m != 32);
        ar1 = s_ready;
        ar0 = n_ready;
        @(posedge clk);
        #1;
        model_edge(en, v, d);
    endtask

    task automatic do_reset();
        enable = 1'b0; blk_valid = 1'b0; blk_data = '0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    function automatic logic [65:0] rand_blk();
        return {($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10, $urandom(), $urandom()};
    endfunction

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        #1;
        n_assert++; if (s_data !== 64'd0) begin n_fail++; $display("FAIL reset_data got %h exp 0", s_data); end
        n_assert++; if ({s_valid, s_under} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b exp 00", {s_valid, s_under}); end
        n_assert++; if (s_seq !== 6'd0) begin n_fail++; $display("FAIL reset_seq got %0d exp 0", s_seq); end
        n_assert++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", s_ready); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_continuous();
        int acc, words;
        do_reset();
        acc = 0; words = 0;
        for (int c = 1; c <= 99; c++) begin
            step(1'b1, 1'b1, rand_blk());
            if (ar1) acc++;
            if (s_valid) words++;
            n_assert++; if (ar1 !== ((c % 33) != 0)) begin n_fail++; $display("FAIL cont_ready c=%0d got %b exp %b", c, ar1, (c % 33) != 0); end
            n_assert++; if (ar0 !== er) begin n_fail++; $display("FAIL cont_ready_n c=%0d got %b exp %b", c, ar0, er); end
            n_assert++; if (s_seq !== 6'(seq_m)) begin n_fail++; $display("FAIL cont_seq c=%0d got %0d exp %0d", c, s_seq, seq_m); end
            n_assert++; if (s_data !== ew1) begin n_fail++; $display("FAIL cont_data_s c=%0d got %h exp %h", c, s_data, ew1); end
            n_assert++; if (n_data !== ew0) begin n_fail++; $display("FAIL cont_data_n c=%0d got %h exp %h", c, n_data, ew0); end
            n_assert++; if (s_under !== 1'b0) begin n_fail++; $display("FAIL cont_under c=%0d got %b exp 0", c, s_under); end
        end
        n_assert++; if (acc !== 96) begin n_fail++; $display("FAIL cont_blocks got %0d exp 96", acc); end
        n_assert++; if (words !== 99) begin n_fail++; $display("FAIL cont_words got %0d exp 99", words); end
    endtask

    task automatic test_bypass_pattern();
        logic [63:0] p;
        logic [63:0] w0;
        p  = 64'h0123_4567_89AB_CDEF;
        w0 = {p[61:0], 2'b01};
        do_reset();
        for (int c = 1; c <= 33; c++) begin
            step(1'b1, 1'b1, {2'b01, p});
            if (c == 1) begin
                n_assert++; if (n_data !== w0) begin n_fail++; $display("FAIL byp_word0 got %h exp %h", n_data, w0); end
            end
            if (c == 2) begin
                n_assert++; if (n_data[1:0] !== p[63:62]) begin n_fail++; $display("FAIL byp_word1 got %b exp %b", n_data[1:0], p[63:62]); end
            end
            if (c == 33) begin
                n_assert++; if (n_data !== p) begin n_fail++; $display("FAIL byp_pause got %h exp %h", n_data, p); end
            end
            n_assert++; if (n_data !== ew0) begin n_fail++; $display("FAIL byp_model c=%0d got %h exp %h", c, n_data, ew0); end
        end
    endtask

    task automatic test_scramble_seed();
        do_reset();
        step(1'b1, 1'b1, {2'b01, 64'd0});
        n_assert++; if (s_data[1:0] !== 2'b01) begin n_fail++; $display("FAIL seed_header got %b exp 01", s_data[1:0]); end
        n_assert++; if (s_data[40:2] !== 39'd0) begin n_fail++; $display("FAIL seed_low got %h exp 0", s_data[40:2]); end
        n_assert++; if (s_data[59:41] !== 19'h7FFFF) begin n_fail++; $display("FAIL seed_mid got %h exp 7ffff", s_data[59:41]); end
        n_assert++; if (s_data !== ew1) begin n_fail++; $display("FAIL seed_word0 got %h exp %h", s_data, ew1); end
        step(1'b1, 1'b1, {2'b01, 64'd0});
        n_assert++; if (s_data !== ew1) begin n_fail++; $display("FAIL seed_word1 got %h exp %h", s_data, ew1); end
    endtask

    task automatic test_underrun();
        logic [5:0] seq0;
        do_reset();
        step(1'b1, 1'b1, rand_blk());
        step(1'b1, 1'b1, rand_blk());
        seq0 = s_seq;
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 1'b0, rand_blk());
            n_assert++; if (s_under !== 1'b1) begin n_fail++; $display("FAIL und_pulse c=%0d got %b exp 1", c, s_under); end
            n_assert++; if (s_data !== ew1) begin n_fail++; $display("FAIL und_data_s c=%0d got %h exp %h", c, s_data, ew1); end
            n_assert++; if (n_data !== ew0) begin n_fail++; $display("FAIL und_data_n c=%0d got %h exp %h", c, n_data, ew0); end
        end
        n_assert++; if (s_seq !== seq0 + 6'd3) begin n_fail++; $display("FAIL und_seq got %0d exp %0d", s_seq, seq0 + 6'd3); end
        step(1'b1, 1'b1, rand_blk());
        n_assert++; if (s_under !== 1'b0) begin n_fail++; $display("FAIL und_clear got %b exp 0", s_under); end
        n_assert++; if (n_data !== ew0) begin n_fail++; $display("FAIL und_after got %h exp %h", n_data, ew0); end
    endtask

    task automatic test_enable_gap();
        do_reset();
        while (seq_m != 17) step(1'b1, 1'b1, rand_blk());
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 1'b1, rand_blk());
            n_assert++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL gap_valid c=%0d got %b exp 0", c, s_valid); end
            n_assert++; if (ar1 !== 1'b0) begin n_fail++; $display("FAIL gap_ready c=%0d got %b exp 0", c, ar1); end
            n_assert++; if (s_seq !== 6'd17) begin n_fail++; $display("FAIL gap_seq c=%0d got %0d exp 17", c, s_seq); end
            n_assert++; if (s_data !== ew1) begin n_fail++; $display("FAIL gap_hold c=%0d got %h exp %h", c, s_data, ew1); end
        end
        for (int c = 0; c < 20; c++) begin
            step(1'b1, 1'b1, rand_blk());
            n_assert++; if (s_valid !== 1'b1) begin n_fail++; $display("FAIL gap_resume_valid c=%0d got %b exp 1", c, s_valid); end
            n_assert++; if (s_seq !== 6'(seq_m)) begin n_fail++; $display("FAIL gap_resume_seq c=%0d got %0d exp %0d", c, s_seq, seq_m); end
            n_assert++; if (s_data !== ew1) begin n_fail++; $display("FAIL gap_resume_s c=%0d got %h exp %h", c, s_data, ew1); end
            n_assert++; if (n_data !== ew0) begin n_fail++; $display("FAIL gap_resume_n c=%0d got %h exp %h", c, n_data, ew0); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        while (seq_m != 20) step(1'b1, 1'b0, rand_blk());
        @(posedge clk);
        #2;
        rst = 1'b1; enable = 1'b0;
        #1;
        n_assert++; if (s_data !== 64'd0) begin n_fail++; $display("FAIL mid_rst_data got %h exp 0", s_data); end
        n_assert++; if ({s_valid, s_under} !== 2'b00) begin n_fail++; $display("FAIL mid_rst_flags got %b exp 00", {s_valid, s_under}); end
        n_assert++; if (s_seq !== 6'd0) begin n_fail++; $display("FAIL mid_rst_seq got %0d exp 0", s_seq); end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step(1'b1, 1'b1, (c == 0) ? {2'b01, 64'd0} : rand_blk());
            n_assert++; if (s_seq !== 6'(seq_m)) begin n_fail++; $display("FAIL mid_seq c=%0d got %0d exp %0d", c, s_seq, seq_m); end
            n_assert++; if (s_data !== ew1) begin n_fail++; $display("FAIL mid_data c=%0d got %h exp %h", c, s_data, ew1); end
        end
    endtask

    task automatic test_random();
        bit en, v;
        do_reset();
        for (int c = 0; c < 250; c++) begin
            en = ($urandom_range(0, 99) < 85);
            v  = ($urandom_range(0, 99) < 70);
            step(en, v, rand_blk());
            n_assert++; if (ar1 !== er) begin n_fail++; $display("FAIL rnd_ready c=%0d got %b exp %b", c, ar1, er); end
            n_assert++; if (s_valid !== ev) begin n_fail++; $display("FAIL rnd_valid c=%0d got %b exp %b", c, s_valid, ev); end
            n_assert++; if (s_seq !== 6'(seq_m)) begin n_fail++; $display("FAIL rnd_seq c=%0d got %0d exp %0d", c, s_seq, seq_m); end
            n_assert++; if (s_under !== eu) begin n_fail++; $display("FAIL rnd_under c=%0d got %b exp %b", c, s_under, eu); end
            n_assert++; if (n_under !== eu) begin n_fail++; $display("FAIL rnd_under_n c=%0d got %b exp %b", c, n_under, eu); end
            n_assert++; if (s_data !== ew1) begin n_fail++; $display("FAIL rnd_data_s c=%0d got %h exp %h", c, s_data, ew1); end
            n_assert++; if (n_data !== ew0) begin n_fail++; $display("FAIL rnd_data_n c=%0d got %h exp %h", c, n_data, ew0); end
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; blk_valid = 1'b0; blk_data = '0;
        model_reset();
        test_reset();
        test_continuous();
        test_bypass_pattern();
        test_scramble_seed();
        test_underrun();
        test_enable_gap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
